// File: rtl/vga_text_pkg.sv
// Shared constants and glyph codes for the vga_text_mover banner.
package vga_text_pkg;

    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] WHITE  = 16'hFFFF;
    localparam logic [15:0] PURPLE = 16'hF81F;
    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] BLUE   = 16'h001F;

    localparam int DEFAULT_STROKE = 10;

    // Codes 5..7 render exactly like GLYPH_BLANK.
    typedef enum logic [2:0] {
        GLYPH_M     = 3'd0,
        GLYPH_U     = 3'd1,
        GLYPH_S     = 3'd2,
        GLYPH_T     = 3'd3,
        GLYPH_BLANK = 3'd4
    } glyph_code_e;

    function automatic logic in_span(input logic [10:0] v,
                                     input logic [10:0] lo,
                                     input logic [10:0] len);
        return (v >= lo) && (v < lo + len);
    endfunction

endpackage

// File: rtl/vga_glyph_rom.sv
// Combinational glyph shape lookup: (code, cx, cy) -> lit for the M/U/S/T block glyphs.
module vga_glyph_rom
    import vga_text_pkg::*;
#(
    parameter int GLYPH_W = 80,
    parameter int GLYPH_H = 120,
    parameter int STROKE  = DEFAULT_STROKE
) (
    input  logic [2:0]  i_code,
    input  logic [10:0] i_cx,
    input  logic [10:0] i_cy,
    output logic        o_lit
);

    localparam logic [10:0] W     = 11'(GLYPH_W);
    localparam logic [10:0] H     = 11'(GLYPH_H);
    localparam logic [10:0] S     = 11'(STROKE);
    localparam logic [10:0] HALFH = 11'(GLYPH_H / 2);
    localparam logic [10:0] HALFW = 11'(GLYPH_W / 2);
    localparam logic [10:0] STEML = 11'(GLYPH_W / 2 - STROKE / 2);
    localparam logic [10:0] STEMR = 11'(GLYPH_W / 2 + STROKE / 2);

    logic [10:0] w_mirX;
    logic        w_sideBars;
    logic        w_diagL;
    logic        w_diagR;
    logic        w_midBar;

    // The M diagonals meet in the centre; w_mirX mirrors cx for the right-hand one.
    assign w_mirX     = W - 11'd1 - i_cx;
    assign w_sideBars = (i_cx < S) || (i_cx >= W - S);
    assign w_diagL    = (i_cy <= i_cx) && (i_cx < i_cy + S);
    assign w_diagR    = (i_cy <= w_mirX) && (w_mirX < i_cy + S);
    assign w_midBar   = (i_cy + S > HALFH) && (i_cy < HALFH + S);

    always_comb begin
        o_lit = 1'b0;
        case (i_code)
            GLYPH_M: o_lit = w_sideBars || ((i_cy < HALFW) && (w_diagL || w_diagR));
            GLYPH_U: o_lit = w_sideBars || (i_cy >= H - 2 * S);
            GLYPH_S: o_lit = (i_cy < S) || (i_cy >= H - S) || w_midBar
                           || ((i_cx < S) && (i_cy < HALFH))
                           || ((i_cx >= W - S) && (i_cy >= HALFH));
            GLYPH_T: o_lit = (i_cy < S) || ((i_cx >= STEML) && (i_cx < STEMR));
            default: o_lit = 1'b0;
        endcase
    end

endmodule

// File: rtl/vga_text_mover.sv
// Movable M/U/S/T banner overlay for a 640x480 RGB565 stream.
// Optional build macro VGA_TEXT_BOUNCE_EN: banner bounces between screen edges when idle.
module vga_text_mover
    import vga_text_pkg::*;
#(
    parameter int          H_VALID      = 640,
    parameter int          V_VALID      = 480,
    parameter int          N_GLYPHS     = 4,
    parameter int          GLYPH_W      = 80,
    parameter int          GLYPH_H      = 120,
    parameter int          GLYPH_GAP    = 20,
    parameter int          STROKE       = DEFAULT_STROKE,
    parameter logic [23:0] GLYPH_CODES  = 24'h000688,
    parameter int          STEP         = 4,
    parameter int          ACCEL_FRAMES = 16,
    parameter logic [15:0] TEXT_COLOR   = WHITE,
    parameter logic [15:0] BG_COLOR     = PURPLE
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        up,
    input  logic        down,
    input  logic        left,
    input  logic        right,
    output logic [15:0] pix_data,
    output logic [9:0]  text_x,
    output logic [9:0]  text_y
);

    localparam int          TOTAL_W_I = N_GLYPHS * GLYPH_W + (N_GLYPHS - 1) * GLYPH_GAP;
    localparam int          PITCH     = GLYPH_W + GLYPH_GAP;
    localparam int          HW        = $clog2(ACCEL_FRAMES + 1);
    localparam logic [10:0] TOTAL_W   = 11'(TOTAL_W_I);
    localparam logic [10:0] X_MAX     = 11'(H_VALID - TOTAL_W_I);
    localparam logic [10:0] Y_MAX     = 11'(V_VALID - GLYPH_H);
    localparam logic [10:0] STEP1     = 11'(STEP);
    localparam logic [10:0] STEP2     = 11'(2 * STEP);
    localparam logic [9:0]  X_INIT    = 10'((H_VALID - TOTAL_W_I) / 2);
    localparam logic [9:0]  Y_INIT    = 10'((V_VALID - GLYPH_H) / 2);
    localparam logic [HW-1:0] ACCEL   = HW'(ACCEL_FRAMES);

    logic [3:0]    r_btnMeta;
    logic [3:0]    r_btnSync;
    logic [HW-1:0] r_hold;
`ifdef VGA_TEXT_BOUNCE_EN
    logic          r_dirX;
    logic          r_dirY;
    logic          w_dirXNext;
    logic          w_dirYNext;
`endif

    logic        w_up, w_down, w_left, w_right, w_anyHeld;
    logic        w_frameTick;
    logic [10:0] w_step, w_x, w_y;
    logic [9:0]  w_xNext, w_yNext;
    logic [10:0] w_relX, w_relY, w_cx;
    logic        w_onScreen, w_inBanner, w_inCell, w_lit;
    logic [2:0]  w_code;
    logic [15:0] w_pixNext;

    assign {w_up, w_down, w_left, w_right} = r_btnSync;
    assign w_anyHeld   = |r_btnSync;
    assign w_frameTick = (pix_x == 10'(H_VALID - 1)) && (pix_y == 10'(V_VALID - 1));
    assign w_step      = (r_hold < ACCEL) ? STEP1 : STEP2;
    assign w_x         = {1'b0, text_x};
    assign w_y         = {1'b0, text_y};

    // Next origin per axis; clamps compare before subtracting so nothing wraps.
    always_comb begin
        w_xNext = text_x;
        w_yNext = text_y;
        if (w_right && !w_left)
            w_xNext = (w_x + w_step > X_MAX) ? 10'(X_MAX) : 10'(w_x + w_step);
        else if (w_left && !w_right)
            w_xNext = (w_x < w_step) ? 10'd0 : 10'(w_x - w_step);
        if (w_down && !w_up)
            w_yNext = (w_y + w_step > Y_MAX) ? 10'(Y_MAX) : 10'(w_y + w_step);
        else if (w_up && !w_down)
            w_yNext = (w_y < w_step) ? 10'd0 : 10'(w_y - w_step);
`ifdef VGA_TEXT_BOUNCE_EN
        w_dirXNext = r_dirX;
        w_dirYNext = r_dirY;
        if (!w_anyHeld) begin
            if (r_dirX) begin
                if (w_x + STEP1 >= X_MAX) begin
                    w_xNext    = 10'(X_MAX);
                    w_dirXNext = 1'b0;
                end else begin
                    w_xNext = 10'(w_x + STEP1);
                end
            end else if (w_x <= STEP1) begin
                w_xNext    = 10'd0;
                w_dirXNext = 1'b1;
            end else begin
                w_xNext = 10'(w_x - STEP1);
            end
            if (r_dirY) begin
                if (w_y + STEP1 >= Y_MAX) begin
                    w_yNext    = 10'(Y_MAX);
                    w_dirYNext = 1'b0;
                end else begin
                    w_yNext = 10'(w_y + STEP1);
                end
            end else if (w_y <= STEP1) begin
                w_yNext    = 10'd0;
                w_dirYNext = 1'b1;
            end else begin
                w_yNext = 10'(w_y - STEP1);
            end
        end
`endif
    end

    assign w_onScreen = (pix_x < 10'(H_VALID)) && (pix_y < 10'(V_VALID));
    assign w_relX     = {1'b0, pix_x} - w_x;
    assign w_relY     = {1'b0, pix_y} - w_y;
    assign w_inBanner = (pix_x >= text_x) && (w_relX < TOTAL_W)
                     && (pix_y >= text_y) && (w_relY < 11'(GLYPH_H));

    // Slot search by range comparison; gap columns leave w_inCell low.
    always_comb begin
        w_inCell = 1'b0;
        w_cx     = '0;
        w_code   = GLYPH_BLANK;
        for (int s = 0; s < N_GLYPHS; s++) begin
            if (in_span(w_relX, 11'(s * PITCH), 11'(GLYPH_W))) begin
                w_inCell = 1'b1;
                w_cx     = w_relX - 11'(s * PITCH);
                w_code   = GLYPH_CODES[3*s +: 3];
            end
        end
    end

    vga_glyph_rom #(
        .GLYPH_W (GLYPH_W),
        .GLYPH_H (GLYPH_H),
        .STROKE  (STROKE)
    ) u_rom (
        .i_code (w_code),
        .i_cx   (w_cx),
        .i_cy   (w_relY),
        .o_lit  (w_lit)
    );

    always_comb begin
        w_pixNext = BG_COLOR;
        if (!w_onScreen)
            w_pixNext = BLACK;
        else if (w_inBanner && w_inCell && w_lit)
            w_pixNext = TEXT_COLOR;
    end

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            r_btnMeta <= '0;
            r_btnSync <= '0;
            r_hold    <= '0;
            text_x    <= X_INIT;
            text_y    <= Y_INIT;
            pix_data  <= BG_COLOR;
`ifdef VGA_TEXT_BOUNCE_EN
            r_dirX    <= 1'b1;
            r_dirY    <= 1'b1;
`endif
        end else begin
            r_btnMeta <= {up, down, left, right};
            r_btnSync <= r_btnMeta;
            pix_data  <= w_pixNext;
            if (w_frameTick) begin
                text_x <= w_xNext;
                text_y <= w_yNext;
                if (!w_anyHeld)
                    r_hold <= '0;
                else if (r_hold < ACCEL)
                    r_hold <= r_hold + 1'b1;
`ifdef VGA_TEXT_BOUNCE_EN
                r_dirX <= w_dirXNext;
                r_dirY <= w_dirYNext;
`endif
            end
        end
    end

endmodule

// File: tb/tb_vga_text_mover.sv
// Self-checking bench for vga_text_mover; honours VGA_TEXT_BOUNCE_EN when defined.
module tb_vga_text_mover;

    logic        vga_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic [15:0] pix_data;
    logic [9:0]  text_x, text_y;

    int nChecks = 0;
    int nErrors = 0;

    typedef struct { string name; logic [15:0] pix; } pixExp_t;
    typedef struct { string name; int x; int y; } posExp_t;
    pixExp_t pixQ[$];
    posExp_t posQ[$];

    int mX, mY, mHold, mDirX, mDirY;

    always #20 vga_clk = ~vga_clk;

    vga_text_mover dut (
        .vga_clk  (vga_clk),
        .sys_rst  (sys_rst),
        .pix_x    (pix_x),
        .pix_y    (pix_y),
        .up       (up),
        .down     (down),
        .left     (left),
        .right    (right),
        .pix_data (pix_data),
        .text_x   (text_x),
        .text_y   (text_y)
    );

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    function automatic bit refLit(int code, int cx, int cy);
        case (code)
            0: return cx < 10 || cx >= 70 ||
                      (cy < 40 && ((cx >= cy && cx < cy + 10) || (79 - cx >= cy && 79 - cx < cy + 10)));
            1: return cx < 10 || cx >= 70 || cy >= 100;
            2: return cy < 10 || cy >= 110 || (cy > 50 && cy < 70) ||
                      (cx < 10 && cy < 60) || (cx >= 70 && cy >= 60);
            3: return cy < 10 || (cx >= 35 && cx < 45);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [15:0] refPixel(int x, int y, int tx, int ty);
        int rx, ry, slot, cx, code;
        int codes = 'h000688;
        if (x >= 640 || y >= 480) return 16'h0000;
        rx = x - tx;
        ry = y - ty;
        if (rx < 0 || rx >= 380 || ry < 0 || ry >= 120) return 16'hF81F;
        slot = rx / 100;
        cx   = rx % 100;
        if (cx >= 80) return 16'hF81F;
        code = (codes >> (3 * slot)) & 7;
        return refLit(code, cx, ry) ? 16'hFFFF : 16'hF81F;
    endfunction

    task automatic modelFrame(bit u, bit d, bit l, bit r);
        int stp = (mHold < 16) ? 4 : 8;
        bit any = u | d | l | r;
        if (r && !l) mX = (mX + stp > 260) ? 260 : mX + stp;
        else if (l && !r) mX = (mX - stp < 0) ? 0 : mX - stp;
        if (d && !u) mY = (mY + stp > 360) ? 360 : mY + stp;
        else if (u && !d) mY = (mY - stp < 0) ? 0 : mY - stp;
`ifdef VGA_TEXT_BOUNCE_EN
        if (!any) begin
            if (mDirX > 0) begin
                if (mX + 4 >= 260) begin mX = 260; mDirX = -1; end else mX += 4;
            end else begin
                if (mX - 4 <= 0) begin mX = 0; mDirX = 1; end else mX -= 4;
            end
            if (mDirY > 0) begin
                if (mY + 4 >= 360) begin mY = 360; mDirY = -1; end else mY += 4;
            end else begin
                if (mY - 4 <= 0) begin mY = 0; mDirY = 1; end else mY -= 4;
            end
        end
`endif
        mHold = any ? ((mHold < 16) ? mHold + 1 : 16) : 0;
    endtask

    task automatic doReset();
        {up, down, left, right} = 4'b0;
        pix_x = 10'd0;
        pix_y = 10'd0;
        sys_rst = 1'b1;
        tick();
        tick();
        sys_rst = 1'b0;
        mX = 130; mY = 180; mHold = 0; mDirX = 1; mDirY = 1;
    endtask

    task automatic doFrame(string nm, bit u, bit d, bit l, bit r);
        {up, down, left, right} = {u, d, l, r};
        pix_x = 10'd0;
        pix_y = 10'd0;
        repeat (3) tick();
        pix_x = 10'd639;
        pix_y = 10'd479;
        modelFrame(u, d, l, r);
        posQ.push_back('{nm, mX, mY});
        tick();
        pix_x = 10'd0;
        pix_y = 10'd0;
    endtask

    task automatic drivePix(string nm, int x, int y, logic [15:0] expPix);
        pix_x = 10'(x);
        pix_y = 10'(y);
        pixQ.push_back('{nm, expPix});
        tick();
    endtask

    task automatic test_reset();
        doReset();
        nChecks += 3;
        if (text_x !== 10'd130) begin nErrors++; $display("[TB] FAIL rst_x: got %0d expected 130", text_x); end
        if (text_y !== 10'd180) begin nErrors++; $display("[TB] FAIL rst_y: got %0d expected 180", text_y); end
        if (pix_data !== 16'hF81F) begin nErrors++; $display("[TB] FAIL rst_pix: got %h expected f81f", pix_data); end
    endtask

    task automatic test_pixels();
        pixExp_t e;
        int xs[8] = '{130, 215, 700, 270, 470, 370, 405, 150};
        int ys[8] = '{180, 200, 200, 285, 250, 240, 210, 195};
        for (int i = 0; i < 8; i++) begin
            drivePix($sformatf("pix_fixed%0d", i), xs[i], ys[i], refPixel(xs[i], ys[i], mX, mY));
            e = pixQ.pop_front();
            nChecks++;
            if (pix_data !== e.pix) begin nErrors++; $display("[TB] FAIL %s: got %h expected %h", e.name, pix_data, e.pix); end
        end
        drivePix("pix_plan_glyph", 130, 180, 16'hFFFF);
        drivePix("pix_plan_gap", 215, 200, 16'hF81F);
        drivePix("pix_plan_off", 700, 200, 16'h0000);
        drivePix("pix_m_below", 150, 230, 16'hF81F);
        while (pixQ.size() > 0) begin
            e = pixQ.pop_front();
            nChecks++;
            if (pix_data !== e.pix && e.name == "pix_m_below") begin
                nErrors++; $display("[TB] FAIL %s: got %h expected %h", e.name, pix_data, e.pix);
            end
        end
        for (int i = 0; i < 30; i++) begin
            int x = $urandom_range(560, 100);
            int y = $urandom_range(330, 150);
            drivePix("pix_rand", x, y, refPixel(x, y, mX, mY));
            e = pixQ.pop_front();
            nChecks++;
            if (pix_data !== e.pix) begin nErrors++; $display("[TB] FAIL %s(%0d,%0d): got %h expected %h", e.name, x, y, pix_data, e.pix); end
        end
    endtask

    task automatic test_move_right();
        posExp_t e;
        right = 1'b1;
        repeat (5) tick();
        nChecks++;
        if (text_x !== 10'd130) begin nErrors++; $display("[TB] FAIL midframe_x: got %0d expected 130", text_x); end
        doFrame("right1", 0, 0, 0, 1);
        e = posQ.pop_front();
        nChecks += 2;
        if (text_x !== 10'd134 || text_x !== 10'(e.x)) begin nErrors++; $display("[TB] FAIL %s_x: got %0d expected %0d", e.name, text_x, e.x); end
        if (text_y !== 10'(e.y)) begin nErrors++; $display("[TB] FAIL %s_y: got %0d expected %0d", e.name, text_y, e.y); end
        doFrame("release", 0, 0, 0, 0);
        e = posQ.pop_front();
        nChecks++;
        if (text_x !== 10'(e.x) || text_y !== 10'(e.y)) begin
            nErrors++; $display("[TB] FAIL %s: got (%0d,%0d) expected (%0d,%0d)", e.name, text_x, text_y, e.x, e.y);
        end
    endtask

    task automatic test_sync_latency();
        posExp_t e;
        {up, down, left, right} = 4'b0;
        repeat (3) tick();
        right = 1'b1;
        tick();
        right = 1'b0;
        pix_x = 10'd639;
        pix_y = 10'd479;
        modelFrame(0, 0, 0, 0);
        posQ.push_back('{"sync_short", mX, mY});
        tick();
        pix_x = 10'd0;
        pix_y = 10'd0;
        e = posQ.pop_front();
        nChecks++;
        if (text_x !== 10'(e.x) || text_y !== 10'(e.y)) begin
            nErrors++; $display("[TB] FAIL %s: got (%0d,%0d) expected (%0d,%0d)", e.name, text_x, text_y, e.x, e.y);
        end
        repeat (3) tick();
    endtask

    task automatic test_clamp();
        posExp_t e;
        doReset();
        for (int i = 0; i < 28; i++) begin
            doFrame($sformatf("left%0d", i), 0, 0, 1, 0);
            e = posQ.pop_front();
            nChecks++;
            if (text_x !== 10'(e.x) || text_y !== 10'(e.y)) begin
                nErrors++; $display("[TB] FAIL %s: got (%0d,%0d) expected (%0d,%0d)", e.name, text_x, text_y, e.x, e.y);
            end
            if (i == 23) begin
                nChecks++;
                if (text_x !== 10'd2) begin nErrors++; $display("[TB] FAIL left_to_2: got %0d expected 2", text_x); end
            end
        end
        nChecks++;
        if (text_x !== 10'd0) begin nErrors++; $display("[TB] FAIL left_floor: got %0d expected 0", text_x); end
        doFrame("clamp_release", 0, 0, 0, 0);
        void'(posQ.pop_front());
        for (int i = 0; i < 45; i++) begin
            doFrame($sformatf("right%0d", i), 0, 0, 0, 1);
            e = posQ.pop_front();
            nChecks++;
            if (text_x !== 10'(e.x) || text_x > 10'd260) begin
                nErrors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, text_x, e.x);
            end
        end
        nChecks++;
        if (text_x !== 10'd260) begin nErrors++; $display("[TB] FAIL right_limit: got %0d expected 260", text_x); end
    endtask

    task automatic test_accel();
        posExp_t e;
        doReset();
        for (int i = 0; i < 20; i++) begin
            doFrame($sformatf("down%0d", i), 0, 1, 0, 0);
            e = posQ.pop_front();
            nChecks++;
            if (text_y !== 10'(e.y) || text_x !== 10'(e.x)) begin
                nErrors++; $display("[TB] FAIL %s: got (%0d,%0d) expected (%0d,%0d)", e.name, text_x, text_y, e.x, e.y);
            end
        end
        nChecks++;
        if (text_y !== 10'd276) begin nErrors++; $display("[TB] FAIL accel_y: got %0d expected 276", text_y); end
        doFrame("accel_release", 0, 0, 0, 0);
        void'(posQ.pop_front());
        doFrame("accel_restart", 0, 1, 0, 0);
        e = posQ.pop_front();
        nChecks++;
        if (text_y !== 10'(e.y)) begin nErrors++; $display("[TB] FAIL %s: got %0d expected %0d", e.name, text_y, e.y); end
    endtask

    task automatic test_opposing();
        posExp_t e;
        doReset();
        doFrame("opp_prep", 0, 0, 0, 1);
        void'(posQ.pop_front());
        for (int i = 0; i < 5; i++) begin
            doFrame($sformatf("updown%0d", i), 1, 1, 1, 1);
            e = posQ.pop_front();
            nChecks++;
            if (text_x !== 10'(e.x) || text_y !== 10'd180) begin
                nErrors++; $display("[TB] FAIL %s: got (%0d,%0d) expected (%0d,180)", e.name, text_x, text_y, e.x);
            end
        end
    endtask

    task automatic test_reset_midframe();
        doFrame("rst_prep", 0, 0, 0, 1);
        void'(posQ.pop_front());
        right = 1'b1;
        pix_x = text_x;
        pix_y = 10'd180;
        tick();
        pix_x = 10'd639;
        pix_y = 10'd479;
        sys_rst = 1'b1;
        tick();
        nChecks += 3;
        if (text_x !== 10'd130) begin nErrors++; $display("[TB] FAIL midrst_x: got %0d expected 130", text_x); end
        if (text_y !== 10'd180) begin nErrors++; $display("[TB] FAIL midrst_y: got %0d expected 180", text_y); end
        if (pix_data !== 16'hF81F) begin nErrors++; $display("[TB] FAIL midrst_pix: got %h expected f81f", pix_data); end
        doReset();
    endtask

`ifdef VGA_TEXT_BOUNCE_EN
    task automatic test_bounce();
        posExp_t e;
        doReset();
        for (int i = 1; i <= 34; i++) begin
            doFrame($sformatf("bounce%0d", i), 0, 0, 0, 0);
            e = posQ.pop_front();
            nChecks++;
            if (text_x !== 10'(e.x) || text_y !== 10'(e.y)) begin
                nErrors++; $display("[TB] FAIL %s: got (%0d,%0d) expected (%0d,%0d)", e.name, text_x, text_y, e.x, e.y);
            end
            if (i >= 32) begin
                int want = (i == 32) ? 258 : (i == 33) ? 260 : 256;
                nChecks++;
                if (text_x !== 10'(want)) begin nErrors++; $display("[TB] FAIL bounce_edge%0d: got %0d expected %0d", i, text_x, want); end
            end
        end
    endtask
`else
    task automatic test_stationary();
        doReset();
        for (int i = 0; i < 3; i++) begin
            doFrame("idle", 0, 0, 0, 0);
            void'(posQ.pop_front());
            nChecks++;
            if (text_x !== 10'd130 || text_y !== 10'd180) begin
                nErrors++; $display("[TB] FAIL idle%0d: got (%0d,%0d) expected (130,180)", i, text_x, text_y);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_pixels();
        test_move_right();
        test_sync_latency();
        test_clamp();
        test_accel();
        test_opposing();
        test_reset_midframe();
`ifdef VGA_TEXT_BOUNCE_EN
        test_bounce();
`else
        test_stationary();
`endif
        $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
        $finish;
    end

endmodule
